// File: rtl/rf_ctrl_pkg.sv
// Shared constants and requester encoding for the register-file write-port controller.
package rf_ctrl_pkg;

   localparam int unsigned REGNUM  = 32;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned KEY_LEN = 5;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LSU = 1'b1
   } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; prio names the requester that wins a tie.
module rr_arb2
   import rf_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_t prio;

   // bit 0 is the ALU, bit 1 the LSU; no grants while in reset
   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (req[0] && (!req[1] || prio == REQ_ALU)) begin
            gnt[0] = 1'b1;
         end else if (req[1]) begin
            gnt[1] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio <= REQ_ALU;
      end else if (gnt[0]) begin
         prio <= REQ_LSU;
      end else if (gnt[1]) begin
         prio <= REQ_ALU;
      end
   end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: arbitrates ALU/LSU writebacks and
// tracks reserved destinations to stall decode on RAW/WAW hazards.
module rf_wb_ctrl
   import rf_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               alu_valid,
   input  logic [KEY_LEN-1:0] alu_rd,
   input  logic [WIDTH-1:0]   alu_data,
   output logic               alu_ready,
   input  logic               lsu_valid,
   input  logic [KEY_LEN-1:0] lsu_rd,
   input  logic [WIDTH-1:0]   lsu_data,
   output logic               lsu_ready,
   input  logic               rsv_valid,
   input  logic [KEY_LEN-1:0] rsv_rd,
   input  logic [KEY_LEN-1:0] readreg1,
   input  logic [KEY_LEN-1:0] readreg2,
   output logic               stall,
   output logic [KEY_LEN-1:0] writereg,
   output logic [WIDTH-1:0]   data,
   output logic               writeEn,
   output logic [REGNUM-1:0]  busy
);

   logic [1:0]         gnt;
   logic [KEY_LEN-1:0] wr_rd;
   logic [WIDTH-1:0]   wr_data;
   logic               rsv_take;
   logic [REGNUM-1:0]  busy_nxt;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({lsu_valid, alu_valid}),
      .gnt (gnt)
   );

   assign alu_ready = gnt[0];
   assign lsu_ready = gnt[1];

   assign wr_rd   = gnt[1] ? lsu_rd   : alu_rd;
   assign wr_data = gnt[1] ? lsu_data : alu_data;

   assign stall    = ~rst & (busy[readreg1] | busy[readreg2] | (rsv_valid & busy[rsv_rd]));
   assign rsv_take = rsv_valid & ~stall & (rsv_rd != KEY_LEN'(0));

   // clear on the edge the register file captures the write; a reservation overrides it
   always_comb begin
      busy_nxt = busy;
      if (writeEn) begin
         busy_nxt[writereg] = 1'b0;
      end
      if (rsv_take) begin
         busy_nxt[rsv_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         writereg <= '0;
         data     <= '0;
         writeEn  <= 1'b0;
         busy     <= '0;
      end else begin
         busy <= busy_nxt;
         if (|gnt) begin
            writereg <= wr_rd;
            data     <= wr_data;
            writeEn  <= (wr_rd != KEY_LEN'(0));
         end else begin
            writeEn  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: per-cycle reference model plus directed literal checks.
module tb_rf_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, lsu_valid, rsv_valid;
   logic [4:0]  alu_rd, lsu_rd, rsv_rd, readreg1, readreg2;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, lsu_ready, stall, writeEn;
   logic [4:0]  writereg;
   logic [31:0] data;
   logic [31:0] busy;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   // reference model state
   int          m_turn = 0;
   logic [31:0] m_busy = '0;
   logic        m_we   = 1'b0;
   logic [4:0]  m_wr   = '0;
   logic [31:0] m_data = '0;

   always #5 clk = ~clk;

   rf_wb_ctrl dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
      .readreg1(readreg1), .readreg2(readreg2),
      .stall(stall), .writereg(writereg), .data(data), .writeEn(writeEn), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // model: whose turn it is, which writes land next cycle, which registers are reserved
   always @(negedge clk) begin : model
      int          win;
      logic        e_stall;
      logic [31:0] nb;
      if (chk_en) begin
         win = -1;
         if (!rst) begin
            if (alu_valid && lsu_valid) win = m_turn;
            else if (alu_valid)         win = 0;
            else if (lsu_valid)         win = 1;
         end
         e_stall = !rst && (m_busy[readreg1] || m_busy[readreg2] || (rsv_valid && m_busy[rsv_rd]));
         check("m_alu_ready", 32'(alu_ready), 32'(win == 0));
         check("m_lsu_ready", 32'(lsu_ready), 32'(win == 1));
         check("m_stall",     32'(stall),     32'(e_stall));
         check("m_writeEn",   32'(writeEn),   32'(m_we));
         check("m_writereg",  32'(writereg),  32'(m_wr));
         check("m_data",      data,           m_data);
         check("m_busy",      busy,           m_busy);
         if (rst) begin
            m_turn = 0; m_busy = '0; m_we = 1'b0; m_wr = '0; m_data = '0;
         end else begin
            nb = m_busy;
            if (m_we) nb[m_wr] = 1'b0;
            if (rsv_valid && !e_stall && rsv_rd != 5'd0) nb[rsv_rd] = 1'b1;
            m_busy = nb;
            if (win == 0) begin
               m_we = (alu_rd != 5'd0); m_wr = alu_rd; m_data = alu_data; m_turn = 1;
            end else if (win == 1) begin
               m_we = (lsu_rd != 5'd0); m_wr = lsu_rd; m_data = lsu_data; m_turn = 0;
            end else begin
               m_we = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0; lsu_valid = 1'b0; rsv_valid = 1'b0;
   endtask

   task automatic do_reset();
      step(); rst = 1'b1; idle();
      @(negedge clk);
      step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; idle();
      alu_rd = '0; lsu_rd = '0; rsv_rd = '0; readreg1 = '0; readreg2 = '0;
      alu_data = '0; lsu_data = '0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_writeEn", 32'(writeEn), 32'd0);
      check("reset_busy", busy, 32'd0);
      check("reset_ready", 32'({alu_ready, lsu_ready}), 32'd0);

      // single ALU write
      step(); rst = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
      @(negedge clk);
      check("t1_alu_ready", 32'(alu_ready), 32'd1);
      step(); idle();
      @(negedge clk);
      check("t1_writeEn", 32'(writeEn), 32'd1);
      check("t1_writereg", 32'(writereg), 32'd5);
      check("t1_data", data, 32'h0000_00AA);

      // both requesters valid from reset: strict alternation starting with ALU
      do_reset();
      step(); rst = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         @(negedge clk);
         check("t2_alu_ready", 32'(alu_ready), 32'((i % 2) == 0));
         check("t2_lsu_ready", 32'(lsu_ready), 32'((i % 2) == 1));
         if (i > 0) check("t2_writereg", 32'(writereg), ((i - 1) % 2 == 0) ? 32'd1 : 32'd2);
      end
      step(); idle();
      @(negedge clk);
      check("t2_last_writereg", 32'(writereg), 32'd2);
      check("t2_last_data", data, 32'h22);

      // RAW stall on reserved rd=7 until the LSU write lands
      step(); rsv_valid = 1'b1; rsv_rd = 5'd7;
      @(negedge clk);
      check("t3_stall_rsv", 32'(stall), 32'd0);
      step(); rsv_valid = 1'b0; readreg1 = 5'd7;
      @(negedge clk);
      check("t3_stall_raw", 32'(stall), 32'd1);
      check("t3_busy", busy, 32'h0000_0080);
      step(); lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
      @(negedge clk);
      check("t3_lsu_ready", 32'(lsu_ready), 32'd1);
      check("t3_stall_grant", 32'(stall), 32'd1);
      step(); lsu_valid = 1'b0;
      @(negedge clk);
      check("t3_writeEn", 32'(writeEn), 32'd1);
      check("t3_stall_wr", 32'(stall), 32'd1);
      step();
      @(negedge clk);
      check("t3_stall_clear", 32'(stall), 32'd0);
      check("t3_busy_clear", busy, 32'd0);

      // WAW: second reservation of rd=9 stalls and changes nothing
      step(); readreg1 = 5'd0; rsv_valid = 1'b1; rsv_rd = 5'd9;
      @(negedge clk);
      check("t4_stall_first", 32'(stall), 32'd0);
      step();
      @(negedge clk);
      check("t4_stall_waw", 32'(stall), 32'd1);
      check("t4_busy", busy, 32'h0000_0200);
      step(); rsv_valid = 1'b0;
      @(negedge clk);
      check("t4_busy_hold", busy, 32'h0000_0200);
      step(); alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      @(negedge clk);
      check("t4_alu_ready", 32'(alu_ready), 32'd1);
      step(); alu_valid = 1'b0;
      @(negedge clk);
      step();
      @(negedge clk);
      check("t4_busy_clear", busy, 32'd0);

      // x0: accepted, never written, never reserved
      step(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
      @(negedge clk);
      check("t5_alu_ready", 32'(alu_ready), 32'd1);
      step(); alu_valid = 1'b0; rsv_valid = 1'b1; rsv_rd = 5'd0;
      @(negedge clk);
      check("t5_writeEn", 32'(writeEn), 32'd0);
      check("t5_stall", 32'(stall), 32'd0);
      step(); rsv_valid = 1'b0;
      @(negedge clk);
      check("t5_busy", busy, 32'd0);

      // reset in the cycle after a grant
      step(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33; rsv_valid = 1'b1; rsv_rd = 5'd12;
      @(negedge clk);
      check("t6_alu_ready", 32'(alu_ready), 32'd1);
      step(); rst = 1'b1; rsv_valid = 1'b0; readreg1 = 5'd12;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
      @(negedge clk);
      check("t6_ready_in_rst", 32'({alu_ready, lsu_ready}), 32'd0);
      check("t6_stall_in_rst", 32'(stall), 32'd0);
      check("t6_pending_we", 32'(writeEn), 32'd1);
      step(); rst = 1'b0;
      @(negedge clk);
      check("t6_writeEn", 32'(writeEn), 32'd0);
      check("t6_busy", busy, 32'd0);
      check("t6_alu_wins", 32'({alu_ready, lsu_ready}), 32'd2);
      step(); idle(); readreg1 = 5'd0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
